// File: rtl/larpix_config_responder.sv
// larpix_config_responder: receives config packets, writes/reads the register map, replies.
// Latency: 6 clocks from rx_empty falling to ld_tx_data when tx_busy is low.
// Backpressure: holds in WAIT_TX while tx_busy is high; rx_empty is only looked at in IDLE.
// Optional feature: define MAGIC_NUMBER_CHECK_EN to drop writes whose magic field is wrong.
module larpix_config_responder #(
  parameter int unsigned WIDTH     = 64,
  parameter logic [31:0] MAGIC     = 32'h89504E47,
  parameter logic [7:0]  GLOBAL_ID = 8'd255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       chip_id,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_empty,
  output logic             uld_rx_data,
  output logic [WIDTH-1:0] tx_data,
  output logic             ld_tx_data,
  input  logic             tx_busy,
  output logic [7:0]       cfg_addr,
  output logic [7:0]       cfg_wdata,
  output logic             cfg_we,
  input  logic [7:0]       cfg_rdata,
  output logic [7:0]       parity_err_cnt,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UNLOAD  = 3'd1,
    CAPTURE = 3'd2,
    DECODE  = 3'd3,
    EXEC    = 3'd4,
    WAIT_TX = 3'd5,
    LOAD    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pkt_q;
  logic [7:0]       reply_dat_q;
  logic [WIDTH-1:0] tx_data_q;
  logic [7:0]       par_cnt_q;
  logic [7:0]       drop_cnt_q;

  logic [1:0]       f_decl;
  logic [7:0]       f_chip;
  logic [7:0]       f_addr;
  logic [7:0]       f_data;
  logic             parity_ok, decl_ok, chip_ok, magic_ok, is_write;
  logic             drop_par, drop_other;
  logic [WIDTH-1:0] reply;

  // Field view of the captured packet; cfg_addr/cfg_wdata follow it so they stay
  // constant from DECODE until the next capture.
  assign f_decl    = pkt_q[1:0];
  assign f_chip    = pkt_q[9:2];
  assign f_addr    = pkt_q[17:10];
  assign f_data    = pkt_q[25:18];
  assign parity_ok = (pkt_q[63] == ~^pkt_q[62:0]);
  assign decl_ok   = f_decl[1];
  assign chip_ok   = (f_chip == chip_id) || (f_chip == GLOBAL_ID);
  assign is_write  = (f_decl == 2'd2);

`ifdef MAGIC_NUMBER_CHECK_EN
  assign magic_ok  = !is_write || (pkt_q[57:26] == MAGIC);
`else
  assign magic_ok  = 1'b1;
`endif

  assign cfg_addr       = f_addr;
  assign cfg_wdata      = f_data;
  assign tx_data        = tx_data_q;
  assign parity_err_cnt = par_cnt_q;
  assign drop_cnt       = drop_cnt_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic, strobes and drop classification (parity first, one counter per drop).
  always_comb begin
    state_d     = state_q;
    uld_rx_data = 1'b0;
    ld_tx_data  = 1'b0;
    cfg_we      = 1'b0;
    drop_par    = 1'b0;
    drop_other  = 1'b0;
    case (state_q)
      IDLE:    if (!rx_empty) state_d = UNLOAD;
      UNLOAD:  begin
        uld_rx_data = 1'b1;
        state_d     = CAPTURE;
      end
      CAPTURE: state_d = DECODE;
      DECODE:  begin
        if (!parity_ok) begin
          drop_par = 1'b1;
          state_d  = IDLE;
        end else if (!decl_ok || !chip_ok || !magic_ok) begin
          drop_other = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC:    begin
        cfg_we  = is_write;
        state_d = WAIT_TX;
      end
      WAIT_TX: if (!tx_busy) state_d = LOAD;
      LOAD:    begin
        ld_tx_data = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reply: echo declare/addr, own chip ID, data from write or read, fixed magic and marker.
  always_comb begin
    reply         = '0;
    reply[1:0]    = f_decl;
    reply[9:2]    = chip_id;
    reply[17:10]  = f_addr;
    reply[25:18]  = reply_dat_q;
    reply[57:26]  = MAGIC;
    reply[62]     = 1'b1;
    reply[63]     = ~^reply[62:0];
  end

  // Packet capture, reply data sampling and the transmit holding register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q       <= '0;
      reply_dat_q <= 8'd0;
      tx_data_q   <= '0;
    end else begin
      if (state_q == CAPTURE) pkt_q <= rx_data;
      if (state_q == EXEC) reply_dat_q <= is_write ? f_data : cfg_rdata;
      if ((state_q == WAIT_TX) && !tx_busy) tx_data_q <= reply;
    end
  end

  // Saturating drop counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_cnt_q  <= 8'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (drop_par && (par_cnt_q != 8'hFF))    par_cnt_q  <= par_cnt_q + 8'd1;
      if (drop_other && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_larpix_config_responder.sv
// Bench for larpix_config_responder: directed scenarios plus randomized packets
// checked against a field-level reference model with a register-map shadow.
module tb_larpix_config_responder;

  localparam logic [31:0] MAGIC = 32'h89504E47;
`ifdef MAGIC_NUMBER_CHECK_EN
  localparam bit MAGIC_CHK = 1'b1;
`else
  localparam bit MAGIC_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  chip_id;
  logic [63:0] rx_data;
  logic        rx_empty;
  logic        uld_rx_data;
  logic [63:0] tx_data;
  logic        ld_tx_data;
  logic        tx_busy;
  logic [7:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        cfg_we;
  logic [7:0]  cfg_rdata;
  logic [7:0]  parity_err_cnt;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  larpix_config_responder dut (
    .clk(clk), .reset_n(reset_n), .chip_id(chip_id),
    .rx_data(rx_data), .rx_empty(rx_empty), .uld_rx_data(uld_rx_data),
    .tx_data(tx_data), .ld_tx_data(ld_tx_data), .tx_busy(tx_busy),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_we(cfg_we), .cfg_rdata(cfg_rdata),
    .parity_err_cnt(parity_err_cnt), .drop_cnt(drop_cnt)
  );

  // Register map attached to the DUT: unwritten locations read addr^0x3C.
  bit [7:0] regmap [256];
  bit       written [256];
  assign cfg_rdata = written[cfg_addr] ? regmap[cfg_addr] : (cfg_addr ^ 8'h3C);
  always @(posedge clk) begin
    if (cfg_we) begin
      regmap[cfg_addr]  <= cfg_wdata;
      written[cfg_addr] <= 1'b1;
    end
  end

  // Reference model state.
  bit [7:0]    m_map [256];
  bit          m_written [256];
  int          exp_par = 0;
  int          exp_drop = 0;
  logic [63:0] last_reply = 64'd0;

  function automatic logic [63:0] mk_pkt(input logic [1:0] d, input logic [7:0] ch,
                                         input logic [7:0] a, input logic [7:0] dt,
                                         input logic [31:0] mg, input bit bad);
    logic [63:0] p;
    p        = '0;
    p[1:0]   = d;
    p[9:2]   = ch;
    p[17:10] = a;
    p[25:18] = dt;
    p[57:26] = mg;
    p[62]    = 1'b1;
    p[63]    = ($countones(p) % 2 == 0);  // make the total number of ones odd
    if (bad) p[63] = ~p[63];
    return p;
  endfunction

  // kind: 0 parity drop, 1 other drop, 2 write accepted, 3 read accepted
  task automatic predict(input logic [63:0] p, output int kind, output logic [63:0] rep);
    logic [1:0] d;
    logic [7:0] ch, a, dt, rdv;
    d = p[1:0]; ch = p[9:2]; a = p[17:10]; dt = p[25:18];
    rdv = m_written[a] ? m_map[a] : (a ^ 8'h3C);
    if ($countones(p) % 2 != 1)                       kind = 0;
    else if (d < 2'd2)                                kind = 1;
    else if (ch != chip_id && ch != 8'd255)           kind = 1;
    else if (MAGIC_CHK && d == 2'd2 && p[57:26] != MAGIC) kind = 1;
    else                                              kind = int'(d);
    rep = mk_pkt(d, chip_id, a, (kind == 2) ? dt : rdv, MAGIC, 1'b0);
  endtask

  task automatic commit(input logic [63:0] p, input int kind, input logic [63:0] rep);
    if (kind == 0) begin
      if (exp_par < 255) exp_par++;
    end else if (kind == 1) begin
      if (exp_drop < 255) exp_drop++;
    end else begin
      last_reply = rep;
      if (kind == 2) begin
        m_map[p[17:10]]     = p[25:18];
        m_written[p[17:10]] = 1'b1;
      end
    end
  endtask

  // Present one packet as the UART receiver would and observe for a bounded window.
  task automatic run_pkt(input logic [63:0] p, input int busy, input int window,
                         output int uld_n, output int we_n, output logic [7:0] we_a,
                         output logic [7:0] we_d, output int ld_n,
                         output logic [63:0] ld_dat, output int lat);
    uld_n = 0; we_n = 0; ld_n = 0; we_a = 8'd0; we_d = 8'd0; ld_dat = 64'd0; lat = -1;
    @(negedge clk);
    rx_data  = p;
    rx_empty = 1'b0;
    tx_busy  = (busy > 0);
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      if (uld_rx_data) begin uld_n++; rx_empty = 1'b1; end
      if (cfg_we) begin we_n++; we_a = cfg_addr; we_d = cfg_wdata; end
      if (ld_tx_data) begin ld_n++; ld_dat = tx_data; lat = c; end
      if (c == busy) tx_busy = 1'b0;
    end
    tx_busy  = 1'b0;
    rx_empty = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rx_empty = 1'b1; tx_busy = 1'b0; rx_data = 64'd0; chip_id = 8'd16;
    repeat (3) @(negedge clk);
    checks++; if ({uld_rx_data, ld_tx_data, cfg_we} !== 3'b000)
      $display("FAIL reset_strobes: got %b want 000", {uld_rx_data, ld_tx_data, cfg_we});
    checks++; if (tx_data !== 64'd0) $display("FAIL reset_tx_data: got %h want 0", tx_data);
    checks++; if ({cfg_addr, cfg_wdata} !== 16'd0)
      $display("FAIL reset_cfg: got addr %h wdata %h want 0", cfg_addr, cfg_wdata);
    checks++; if ({parity_err_cnt, drop_cnt} !== 16'd0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", parity_err_cnt, drop_cnt);
    errors += ({uld_rx_data, ld_tx_data, cfg_we} !== 3'b000) + (tx_data !== 64'd0)
            + ({cfg_addr, cfg_wdata} !== 16'd0) + ({parity_err_cnt, drop_cnt} !== 16'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (uld_rx_data !== 1'b0) begin
      errors++; $display("FAIL idle_no_unload: got %b want 0", uld_rx_data);
    end
  endtask

  task automatic test_write();
    logic [63:0] p, rep, ld_dat; int kind, uld_n, we_n, ld_n, lat; logic [7:0] wa, wd;
    p = mk_pkt(2'd2, 8'd16, 8'h05, 8'hA5, MAGIC, 1'b0);
    predict(p, kind, rep);
    run_pkt(p, 0, 20, uld_n, we_n, wa, wd, ld_n, ld_dat, lat);
    checks++; if (uld_n !== 1) begin errors++; $display("FAIL wr_unload: got %0d want 1", uld_n); end
    checks++; if (we_n !== 1 || wa !== 8'h05 || wd !== 8'hA5) begin
      errors++; $display("FAIL wr_cfg_we: got n=%0d addr=%h data=%h want 1/05/a5", we_n, wa, wd); end
    checks++; if (ld_n !== 1 || lat !== 6) begin
      errors++; $display("FAIL wr_ld_latency: got n=%0d lat=%0d want 1/6", ld_n, lat); end
    checks++; if (ld_dat[1:0] !== 2'd2 || ld_dat[9:2] !== 8'd16 || ld_dat[25:18] !== 8'hA5
                  || ld_dat[62] !== 1'b1 || ($countones(ld_dat) % 2) != 1) begin
      errors++; $display("FAIL wr_reply_fields: got %h", ld_dat); end
    checks++; if (ld_dat !== rep) begin
      errors++; $display("FAIL wr_reply: got %h want %h", ld_dat, rep); end
    commit(p, kind, rep);
  endtask

  task automatic test_read();
    logic [63:0] p, rep, ld_dat; int kind, uld_n, we_n, ld_n, lat; logic [7:0] wa, wd;
    p = mk_pkt(2'd3, 8'd255, 8'h05, 8'h00, MAGIC, 1'b0);
    predict(p, kind, rep);
    run_pkt(p, 0, 20, uld_n, we_n, wa, wd, ld_n, ld_dat, lat);
    checks++; if (we_n !== 0) begin errors++; $display("FAIL rd_no_write: got %0d want 0", we_n); end
    checks++; if (ld_n !== 1 || ld_dat[1:0] !== 2'd3 || ld_dat[9:2] !== 8'd16 || ld_dat[25:18] !== 8'hA5) begin
      errors++; $display("FAIL rd_reply_fields: got n=%0d reply=%h", ld_n, ld_dat); end
    checks++; if (ld_dat !== rep) begin
      errors++; $display("FAIL rd_reply: got %h want %h", ld_dat, rep); end
    commit(p, kind, rep);
    checks++; if (tx_data !== last_reply) begin
      errors++; $display("FAIL rd_tx_hold: got %h want %h", tx_data, last_reply); end
  endtask

  task automatic test_drops();
    logic [63:0] p, rep, ld_dat; int kind, uld_n, we_n, ld_n, lat; logic [7:0] wa, wd;
    p = mk_pkt(2'd2, 8'd16, 8'h06, 8'h77, MAGIC, 1'b1);
    predict(p, kind, rep);
    run_pkt(p, 0, 20, uld_n, we_n, wa, wd, ld_n, ld_dat, lat);
    commit(p, kind, rep);
    checks++; if (we_n !== 0 || ld_n !== 0) begin
      errors++; $display("FAIL par_drop_silent: got we=%0d ld=%0d want 0/0", we_n, ld_n); end
    checks++; if (parity_err_cnt !== 8'd1 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL par_drop_cnt: got %0d/%0d want 1/0", parity_err_cnt, drop_cnt); end
    p = mk_pkt(2'd3, 8'd31, 8'h05, 8'h00, MAGIC, 1'b0);
    predict(p, kind, rep);
    run_pkt(p, 0, 20, uld_n, we_n, wa, wd, ld_n, ld_dat, lat);
    commit(p, kind, rep);
    checks++; if (we_n !== 0 || ld_n !== 0) begin
      errors++; $display("FAIL chip_drop_silent: got we=%0d ld=%0d want 0/0", we_n, ld_n); end
    checks++; if (parity_err_cnt !== 8'd1 || drop_cnt !== 8'd1) begin
      errors++; $display("FAIL chip_drop_cnt: got %0d/%0d want 1/1", parity_err_cnt, drop_cnt); end
    checks++; if (tx_data !== last_reply) begin
      errors++; $display("FAIL drop_tx_hold: got %h want %h", tx_data, last_reply); end
  endtask

  task automatic test_busy();
    logic [63:0] p, rep, ld_dat; int kind, uld_n, we_n, ld_n, lat; logic [7:0] wa, wd;
    p = mk_pkt(2'd2, 8'd16, 8'h22, 8'h9C, MAGIC, 1'b0);
    predict(p, kind, rep);
    run_pkt(p, 20, 40, uld_n, we_n, wa, wd, ld_n, ld_dat, lat);
    checks++; if (ld_n !== 1 || lat !== 21) begin
      errors++; $display("FAIL busy_ld_timing: got n=%0d lat=%0d want 1/21", ld_n, lat); end
    checks++; if (ld_dat !== rep || we_n !== 1) begin
      errors++; $display("FAIL busy_reply: got %h we=%0d want %h we=1", ld_dat, we_n, rep); end
    commit(p, kind, rep);
  endtask

  task automatic test_magic();
    logic [63:0] p, rep, ld_dat; int kind, uld_n, we_n, ld_n, lat; logic [7:0] wa, wd;
    p = mk_pkt(2'd2, 8'd16, 8'h40, 8'h3C, 32'd0, 1'b0);
    predict(p, kind, rep);
    run_pkt(p, 0, 20, uld_n, we_n, wa, wd, ld_n, ld_dat, lat);
    commit(p, kind, rep);
    checks++; if (we_n !== int'(kind == 2) || ld_n !== int'(kind == 2)) begin
      errors++; $display("FAIL magic_accept: got we=%0d ld=%0d want %0d", we_n, ld_n, int'(kind == 2)); end
    checks++; if (drop_cnt !== exp_drop[7:0]) begin
      errors++; $display("FAIL magic_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
    checks++; if (kind == 2 && (ld_dat !== rep || ld_dat[57:26] !== MAGIC)) begin
      errors++; $display("FAIL magic_reply: got %h want %h", ld_dat, rep); end
  endtask

  task automatic test_reset_midop();
    logic [63:0] p, rep, ld_dat; int kind, uld_n, we_n, ld_n, lat; logic [7:0] wa, wd;
    int stray;
    p = mk_pkt(2'd2, 8'd16, 8'h33, 8'h5A, MAGIC, 1'b0);
    @(negedge clk); rx_data = p; rx_empty = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (uld_rx_data) rx_empty = 1'b1;
    end
    @(posedge clk); #1 reset_n = 1'b0;   // DUT has just entered EXEC
    @(negedge clk);
    exp_par = 0; exp_drop = 0; last_reply = 64'd0;
    checks++; if (cfg_we !== 1'b0 || ld_tx_data !== 1'b0 || cfg_addr !== 8'd0 || cfg_wdata !== 8'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got we=%b ld=%b addr=%h wd=%h want 0", cfg_we, ld_tx_data, cfg_addr, cfg_wdata); end
    checks++; if (tx_data !== 64'd0 || parity_err_cnt !== 8'd0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_mid_state: got tx=%h cnt=%0d/%0d want 0", tx_data, parity_err_cnt, drop_cnt); end
    rx_empty = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cfg_we || ld_tx_data) stray++;
    end
    checks++; if (stray !== 0 || written[8'h33] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_discard: got stray=%0d written=%b want 0/0", stray, written[8'h33]); end
    predict(p, kind, rep);
    run_pkt(p, 0, 20, uld_n, we_n, wa, wd, ld_n, ld_dat, lat);
    checks++; if (we_n !== 1 || wd !== 8'h5A || ld_n !== 1 || ld_dat !== rep || lat !== 6) begin
      errors++; $display("FAIL rst_mid_next: got we=%0d wd=%h ld=%0d lat=%0d reply=%h want 1/5a/1/6/%h", we_n, wd, ld_n, lat, ld_dat, rep); end
    commit(p, kind, rep);
  endtask

  task automatic test_random();
    logic [63:0] p, rep, ld_dat; int kind, uld_n, we_n, ld_n, lat, busy, exp_lat;
    logic [7:0] wa, wd, ch;
    chip_id = 8'($urandom_range(1, 254));
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: ch = chip_id;
        1: ch = 8'd255;
        default: ch = 8'($urandom);
      endcase
      p = mk_pkt(2'($urandom), ch, 8'($urandom_range(0, 15)), 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? $urandom : MAGIC, $urandom_range(0, 5) == 0);
      busy = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 12);
      exp_lat = (busy + 1 > 6) ? busy + 1 : 6;
      predict(p, kind, rep);
      run_pkt(p, busy, 24, uld_n, we_n, wa, wd, ld_n, ld_dat, lat);
      commit(p, kind, rep);
      checks++; if (uld_n !== 1) begin errors++; $display("FAIL rnd_unload[%0d]: got %0d want 1", i, uld_n); end
      checks++; if (we_n !== int'(kind == 2) || (kind == 2 && (wa !== p[17:10] || wd !== p[25:18]))) begin
        errors++; $display("FAIL rnd_write[%0d]: got n=%0d %h/%h kind=%0d", i, we_n, wa, wd, kind); end
      checks++; if (ld_n !== int'(kind >= 2) || (kind >= 2 && (ld_dat !== rep || lat !== exp_lat))) begin
        errors++; $display("FAIL rnd_reply[%0d]: got n=%0d lat=%0d %h want lat=%0d %h", i, ld_n, lat, ld_dat, exp_lat, rep); end
      checks++; if (parity_err_cnt !== exp_par[7:0] || drop_cnt !== exp_drop[7:0]) begin
        errors++; $display("FAIL rnd_counters[%0d]: got %0d/%0d want %0d/%0d", i, parity_err_cnt, drop_cnt, exp_par, exp_drop); end
      checks++; if (tx_data !== last_reply) begin
        errors++; $display("FAIL rnd_tx_hold[%0d]: got %h want %h", i, tx_data, last_reply); end
    end
  endtask

  task automatic test_saturation();
    logic [63:0] p, rep, ld_dat; int kind, uld_n, we_n, ld_n, lat; logic [7:0] wa, wd;
    for (int i = 0; i < 260; i++) begin
      p = mk_pkt(2'd3, chip_id, 8'd1, 8'd0, MAGIC, 1'b1);
      predict(p, kind, rep);
      run_pkt(p, 0, 6, uld_n, we_n, wa, wd, ld_n, ld_dat, lat);
      commit(p, kind, rep);
    end
    checks++; if (parity_err_cnt !== 8'd255 || drop_cnt !== exp_drop[7:0]) begin
      errors++; $display("FAIL sat_parity: got %0d/%0d want 255/%0d", parity_err_cnt, drop_cnt, exp_drop); end
    for (int i = 0; i < 260; i++) begin
      p = mk_pkt(2'd0, chip_id, 8'd1, 8'd0, MAGIC, 1'b0);
      predict(p, kind, rep);
      run_pkt(p, 0, 6, uld_n, we_n, wa, wd, ld_n, ld_dat, lat);
      commit(p, kind, rep);
    end
    checks++; if (drop_cnt !== 8'd255 || parity_err_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_drop: got %0d/%0d want 255/255", parity_err_cnt, drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_drops();
    test_busy();
    test_magic();
    test_reset_midop();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
